// File: rtl/level_sensor_debouncer_if.sv
// Float-switch sensor bundle between the level meter front end and the debouncer.
// The tick enable and raw switch vector go in; the cleaned vector, level and status come out.
interface level_sensor_debouncer_if #(
  parameter int N_SENSORS = 8,
  parameter int LEVEL_W   = 4
);
  logic                 tick_1khz;
  logic [N_SENSORS-1:0] sensor_raw;
  logic [N_SENSORS-1:0] sensor_stable;
  logic [LEVEL_W-1:0]   level;
  logic                 level_changed;
  logic                 fault;

  modport master (
    output tick_1khz, sensor_raw,
    input  sensor_stable, level, level_changed, fault
  );

  modport slave (
    input  tick_1khz, sensor_raw,
    output sensor_stable, level, level_changed, fault
  );
endinterface

// File: rtl/level_sensor_debouncer.sv
// Synchronises and debounces the float-switch inputs on the 1 kHz tick, then encodes
// the thermometer vector into a tank level with change strobe and fault flag.
module level_sensor_debouncer #(
  parameter int N_SENSORS   = 8,
  parameter int DEBOUNCE_MS = 20,
  parameter int LEVEL_W     = 4
) (
  input  logic                     clk_100MHz,
  input  logic                     reset_n,
  level_sensor_debouncer_if.slave  bus
);

  localparam int                 CNT_W    = $clog2(DEBOUNCE_MS + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_MS - 1);

  logic [N_SENSORS-1:0] sync1_q, sync2_q;
  logic [N_SENSORS-1:0] stable_q, stable_d;
  logic [N_SENSORS-1:0] stable_inc;
  logic [CNT_W-1:0]     cnt_q [N_SENSORS];
  logic [CNT_W-1:0]     cnt_d [N_SENSORS];
  logic [LEVEL_W-1:0]   level_q, level_d, ones;
  logic                 changed_q, changed_d;
  logic                 fault_q, fault_d;
  logic                 thermo;

  // A count only advances while the synced bit disagrees with the accepted value;
  // any tick of agreement throws the partial count away.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < N_SENSORS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (bus.tick_1khz) begin
        if (sync2_q[i] == stable_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = sync2_q[i];
          cnt_d[i]    = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // 0..01..1 plus one is a power of two, so it shares no set bit with the original.
  always_comb begin
    ones       = '0;
    stable_inc = stable_q + N_SENSORS'(1);
    thermo     = ((stable_q & stable_inc) == '0);
    for (int i = 0; i < N_SENSORS; i++) begin
      ones = ones + LEVEL_W'(stable_q[i]);
    end
    level_d   = level_q;
    fault_d   = 1'b1;
    changed_d = 1'b0;
    if (thermo) begin
      fault_d   = 1'b0;
      level_d   = ones;
      changed_d = (ones != level_q);
    end
  end

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      stable_q  <= '0;
      level_q   <= '0;
      changed_q <= 1'b0;
      fault_q   <= 1'b0;
      for (int i = 0; i < N_SENSORS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= bus.sensor_raw;
      sync2_q   <= sync1_q;
      stable_q  <= stable_d;
      level_q   <= level_d;
      changed_q <= changed_d;
      fault_q   <= fault_d;
      for (int i = 0; i < N_SENSORS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.sensor_stable = stable_q;
  assign bus.level         = level_q;
  assign bus.level_changed = changed_q;
  assign bus.fault         = fault_q;

endmodule

// File: tb/tb_level_sensor_debouncer.sv
// Bench for level_sensor_debouncer: directed scenarios plus random stimulus, checked by a
// sliding-window reference model and a scoreboard of expected level-change pulses.
module tb_level_sensor_debouncer;

  localparam int N  = 8;
  localparam int DB = 20;
  localparam int LW = 4;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  logic tick_hold = 1'b0;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  level_sensor_debouncer_if #(.N_SENSORS(N), .LEVEL_W(LW)) sif ();

  level_sensor_debouncer #(
    .N_SENSORS  (N),
    .DEBOUNCE_MS(DB),
    .LEVEL_W    (LW)
  ) dut (
    .clk_100MHz(clk),
    .reset_n   (reset_n),
    .bus       (sif.slave)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [N-1:0]  stable_m = '0;
  logic [N-1:0]  nxt_m    = '0;
  logic [N-1:0]  h1       = '0;
  logic [N-1:0]  h2       = '0;
  logic [LW-1:0] level_m  = '0;
  logic          fault_m  = 1'b0;
  logic [N-1:0]  hist[$];
  int            exp_q[$];
  int            pc;
  bit            all_diff;
  int            e;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // A bit is accepted when the last DB tick samples all disagree with its stable value.
  // Each tick samples the raw value present two clock edges earlier.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_m = '0;
      h1       = '0;
      h2       = '0;
      level_m  = '0;
      fault_m  = 1'b0;
      hist.delete();
      exp_q.delete();
    end else begin
      pc = $countones(stable_m);
      if (stable_m == N'((1 << pc) - 1)) begin
        fault_m = 1'b0;
        if (pc != int'(level_m)) exp_q.push_back(pc);
        level_m = LW'(pc);
      end else begin
        fault_m = 1'b1;
      end
      if (sif.tick_1khz) begin
        hist.push_back(h2);
        if (hist.size() > DB) void'(hist.pop_front());
        nxt_m = stable_m;
        if (hist.size() == DB) begin
          for (int b = 0; b < N; b++) begin
            all_diff = 1'b1;
            for (int k = 0; k < DB; k++) begin
              if (hist[k][b] == stable_m[b]) all_diff = 1'b0;
            end
            if (all_diff) nxt_m[b] = ~stable_m[b];
          end
        end
        stable_m = nxt_m;
      end
      h2 = h1;
      h1 = sif.sensor_raw;
    end
  end

  // Monitor: compares state every cycle and consumes expected pulses from the scoreboard.
  always @(negedge clk) begin
    check("stable", 32'(sif.sensor_stable), 32'(stable_m));
    check("level", 32'(sif.level), 32'(level_m));
    check("fault", 32'(sif.fault), 32'(fault_m));
    if (sif.level_changed) begin
      pulses++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pulse_unexpected: got level_changed=1 level=%0d expected no pulse at %0t",
                 sif.level, $time);
      end else begin
        e = exp_q.pop_front();
        check("pulse_level", 32'(sif.level), 32'(e));
      end
    end else if (exp_q.size() != 0) begin
      checks++;
      errors++;
      e = exp_q.pop_front();
      $display("FAIL pulse_missing: got level_changed=0 expected pulse to level %0d at %0t",
               e, $time);
    end
  end

  initial begin
    sif.tick_1khz = 1'b0;
    forever begin
      repeat (9) @(posedge clk);
      #1 sif.tick_1khz = 1'b1;
      @(posedge clk);
      #1 sif.tick_1khz = tick_hold;
    end
  end

  task automatic wait_ticks(int n);
    int k = 0;
    while (k < n) begin
      @(posedge clk);
      if (sif.tick_1khz) k++;
    end
    #1;
  endtask

  task automatic do_reset(int clocks);
    @(posedge clk);
    #1 reset_n = 1'b0;
    repeat (clocks) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0] v;
    sif.sensor_raw = '1;
    #2 reset_n = 1'b0;
    repeat (12) begin
      @(negedge clk);
      check("rst_stable", 32'(sif.sensor_stable), 32'h0);
      check("rst_level", 32'(sif.level), 32'h0);
      check("rst_fault", 32'(sif.fault), 32'h0);
      check("rst_changed", 32'(sif.level_changed), 32'h0);
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
    sif.sensor_raw = '0;
    wait_ticks(25);

    sif.sensor_raw = 8'h01;
    wait_ticks(5);
    sif.sensor_raw = 8'h00;
    wait_ticks(25);
    check("glitch_stable", 32'(sif.sensor_stable), 32'h00);
    check("glitch_pulses", 32'(pulses), 32'd0);
    sif.sensor_raw = 8'h01;
    wait_ticks(22);
    check("lvl1_stable", 32'(sif.sensor_stable), 32'h01);
    check("lvl1_level", 32'(sif.level), 32'd1);
    check("lvl1_pulses", 32'(pulses), 32'd1);

    sif.sensor_raw = 8'h07;
    wait_ticks(22);
    check("lvl3_stable", 32'(sif.sensor_stable), 32'h07);
    check("lvl3_level", 32'(sif.level), 32'd3);
    check("lvl3_pulses", 32'(pulses), 32'd2);

    sif.sensor_raw = 8'h05;
    wait_ticks(22);
    check("fault_set", 32'(sif.fault), 32'd1);
    check("fault_level", 32'(sif.level), 32'd3);
    check("fault_pulses", 32'(pulses), 32'd2);
    sif.sensor_raw = 8'h07;
    wait_ticks(22);
    check("recover_fault", 32'(sif.fault), 32'd0);
    check("recover_level", 32'(sif.level), 32'd3);
    check("recover_pulses", 32'(pulses), 32'd2);

    sif.sensor_raw = 8'h0F;
    wait_ticks(10);
    #1 reset_n = 1'b0;
    @(negedge clk);
    check("midrst_stable", 32'(sif.sensor_stable), 32'h0);
    check("midrst_level", 32'(sif.level), 32'h0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    wait_ticks(15);
    check("postrst_partial", 32'(sif.sensor_stable), 32'h00);
    wait_ticks(7);
    check("postrst_stable", 32'(sif.sensor_stable), 32'h0F);
    check("postrst_level", 32'(sif.level), 32'd4);
    check("postrst_pulses", 32'(pulses), 32'd3);

    for (int k = 0; k < 67; k++) begin
      sif.sensor_raw = sif.sensor_raw ^ 8'h08;
      wait_ticks(3);
    end
    sif.sensor_raw = 8'h0F;
    wait_ticks(22);
    check("toggle_stable", 32'(sif.sensor_stable), 32'h0F);
    check("toggle_pulses", 32'(pulses), 32'd3);

    tick_hold = 1'b1;
    for (int k = 0; k < 12; k++) begin
      sif.sensor_raw = N'($urandom);
      wait_ticks($urandom_range(5, 40));
    end
    tick_hold = 1'b0;

    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        v = N'((1 << $urandom_range(0, N)) - 1);
      end else begin
        v = N'($urandom);
      end
      sif.sensor_raw = v;
      if ($urandom_range(0, 14) == 0) do_reset($urandom_range(1, 5));
      wait_ticks($urandom_range(3, 30));
    end

    wait_ticks(25);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
